// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives the data-bus handshake, stalls the pipeline while a
// memory op is in flight, and steers/extends byte lanes before handing the result to mem.
`timescale 1ns/1ps

module mem_lsu #(
    parameter int ADDR_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
    input  logic [3:0]             mem_op_i,
    input  logic [RDATA_WIDTH-1:0] mem_wdata_i,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
    output logic [3:0]             dbus_be_o,
    output logic [RDATA_WIDTH-1:0] dbus_wdata_o,
    input  logic                   dbus_gnt_i,
    input  logic                   dbus_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] dbus_rdata_i,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [RDATA_WIDTH-1:0] reg_wdata_o,
    output logic                   stall_req_o,
    output logic                   misalign_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             op_p1;
    logic [ADDR_WIDTH-1:0]  addr_p1;
    logic [RADDR_WIDTH-1:0] waddr_p1;
    logic                   we_p1;
    logic [3:0]             be_p1;
    logic [RDATA_WIDTH-1:0] wdata_p1;
    logic [RDATA_WIDTH-1:0] rdata_p2;
    logic                   latch_en;
    logic                   cap_en;
    logic                   in_load;
    logic                   in_store;
    logic                   in_misaligned;
    logic [ADDR_WIDTH-1:0]  in_addr;

    function automatic logic is_load_op(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            OP_LB, OP_LBU, OP_SB: lane_be = 4'b0001 << lane;
            OP_LH, OP_LHU, OP_SH: lane_be = lane[1] ? 4'b1100 : 4'b0011;
            default:              lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] data);
        case (op)
            OP_SB:   lane_wdata = {4{data[7:0]}};
            OP_SH:   lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    // Pull the addressed lane out of the bus word and widen it for the register file.
    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = word >> {lane, 3'b000};
        b = shifted[7:0];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   load_extend = {{24{b[7]}}, b};
            OP_LBU:  load_extend = {24'd0, b};
            OP_LH:   load_extend = {{16{h[15]}}, h};
            OP_LHU:  load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

    always_comb begin
        in_addr       = reg_wdata_i[ADDR_WIDTH-1:0];
        in_load       = is_load_op(mem_op_i);
        in_store      = is_store_op(mem_op_i);
        in_misaligned = 1'b0;
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: in_misaligned = in_addr[0];
            OP_LW, OP_SW:         in_misaligned = |in_addr[1:0];
            default:              in_misaligned = 1'b0;
        endcase
    end

    // ---- stage boundary: request fields latched in IDLE, load word captured on rvalid ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_p1    <= '0;
            addr_p1  <= '0;
            waddr_p1 <= '0;
            we_p1    <= 1'b0;
            be_p1    <= '0;
            wdata_p1 <= '0;
            rdata_p2 <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                op_p1    <= mem_op_i;
                addr_p1  <= in_addr;
                waddr_p1 <= reg_waddr_i;
                we_p1    <= reg_we_i;
                be_p1    <= lane_be(mem_op_i, in_addr[1:0]);
                wdata_p1 <= lane_wdata(mem_op_i, mem_wdata_i);
            end
            if (cap_en)
                rdata_p2 <= dbus_rdata_i;
        end
    end

    // Outputs are forced to zero while reset is asserted so an in-flight request drops at once.
    always_comb begin
        state_d      = state_q;
        latch_en     = 1'b0;
        cap_en       = 1'b0;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = '0;
        dbus_be_o    = '0;
        dbus_wdata_o = '0;
        reg_waddr_o  = '0;
        reg_we_o     = 1'b0;
        reg_wdata_o  = '0;
        stall_req_o  = 1'b0;
        misalign_o   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    reg_waddr_o = reg_waddr_i;
                    reg_wdata_o = reg_wdata_i;
                    reg_we_o    = reg_we_i;
                    if (in_load || in_store) begin
                        reg_we_o = 1'b0;
                        if (in_misaligned) begin
                            misalign_o = 1'b1;
                        end else begin
                            stall_req_o = 1'b1;
                            latch_en    = 1'b1;
                            state_d     = REQ;
                        end
                    end
                end
                REQ: begin
                    dbus_req_o   = 1'b1;
                    dbus_we_o    = is_store_op(op_p1);
                    dbus_addr_o  = {addr_p1[ADDR_WIDTH-1:2], 2'b00};
                    dbus_be_o    = be_p1;
                    dbus_wdata_o = wdata_p1;
                    stall_req_o  = 1'b1;
                    if (dbus_gnt_i) begin
                        if (is_store_op(op_p1)) begin
                            state_d = DONE;
                        end else if (dbus_rvalid_i) begin
                            cap_en  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    stall_req_o = 1'b1;
                    if (dbus_rvalid_i) begin
                        cap_en  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d     = IDLE;
                    reg_waddr_o = waddr_p1;
                    if (is_load_op(op_p1)) begin
                        reg_we_o    = we_p1;
                        reg_wdata_o = load_extend(op_p1, addr_p1[1:0], rdata_p2);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: load results go through a scoreboard queue filled at issue
// and drained when the write-back appears; bus fields and stall timing are checked inline.
`timescale 1ns/1ps

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_wdata_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stall_req_o;
    logic        misalign_o;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [36:0] exp_q[$];

    mem_lsu dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .reg_waddr_i   (reg_waddr_i),
        .reg_we_i      (reg_we_i),
        .reg_wdata_i   (reg_wdata_i),
        .mem_op_i      (mem_op_i),
        .mem_wdata_i   (mem_wdata_i),
        .dbus_req_o    (dbus_req_o),
        .dbus_we_o     (dbus_we_o),
        .dbus_addr_o   (dbus_addr_o),
        .dbus_be_o     (dbus_be_o),
        .dbus_wdata_o  (dbus_wdata_o),
        .dbus_gnt_i    (dbus_gnt_i),
        .dbus_rvalid_i (dbus_rvalid_i),
        .dbus_rdata_i  (dbus_rdata_i),
        .reg_waddr_o   (reg_waddr_o),
        .reg_we_o      (reg_we_o),
        .reg_wdata_o   (reg_wdata_o),
        .stall_req_o   (stall_req_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                         input logic we, input logic [31:0] rs2);
        mem_op_i    = op;
        reg_wdata_i = addr;
        reg_waddr_i = rd;
        reg_we_i    = we;
        mem_wdata_i = rs2;
    endtask

    // One complete memory op from IDLE to DONE, followed by a NONE cycle.
    task automatic mem_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rs2, input logic [31:0] rdata,
                           input int gnt_dly, input int rv_dly, input logic [31:0] exp_baddr,
                           input logic [3:0] exp_be, input logic [31:0] exp_bwdata,
                           input logic [31:0] exp_res, input int exp_stall);
        logic        is_load;
        logic [36:0] ent;
        int          stall_cnt;
        is_load   = (op <= 4'd5);
        stall_cnt = 0;
        drive(op, addr, rd, 1'b1, rs2);
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'h0;
        if (is_load) exp_q.push_back({rd, exp_res});
        #4;
        chk({tag, ".idle_we"}, 32'(reg_we_o), 32'd0);
        chk({tag, ".idle_req"}, 32'(dbus_req_o), 32'd0);
        stall_cnt += int'(stall_req_o);
        step();
        for (int i = 0; i <= gnt_dly; i++) begin
            dbus_gnt_i    = (i == gnt_dly);
            dbus_rvalid_i = (i == gnt_dly) && is_load && (rv_dly == 0);
            dbus_rdata_i  = rdata;
            #4;
            chk({tag, ".req"}, 32'(dbus_req_o), 32'd1);
            chk({tag, ".addr"}, dbus_addr_o, exp_baddr);
            chk({tag, ".be"}, 32'(dbus_be_o), 32'(exp_be));
            chk({tag, ".bwe"}, 32'(dbus_we_o), 32'(!is_load));
            if (!is_load) chk({tag, ".bwdata"}, dbus_wdata_o, exp_bwdata);
            chk({tag, ".req_we"}, 32'(reg_we_o), 32'd0);
            stall_cnt += int'(stall_req_o);
            step();
        end
        if (is_load) begin
            for (int j = 1; j <= rv_dly; j++) begin
                dbus_gnt_i    = 1'b0;
                dbus_rvalid_i = (j == rv_dly);
                dbus_rdata_i  = rdata;
                #4;
                chk({tag, ".wait_req"}, 32'(dbus_req_o), 32'd0);
                chk({tag, ".wait_we"}, 32'(reg_we_o), 32'd0);
                stall_cnt += int'(stall_req_o);
                step();
            end
        end
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'hA5A5_A5A5;
        #4;
        chk({tag, ".done_stall"}, 32'(stall_req_o), 32'd0);
        chk({tag, ".done_req"}, 32'(dbus_req_o), 32'd0);
        chk({tag, ".done_we"}, 32'(reg_we_o), 32'(is_load));
        if (reg_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd0, 32'd1);
            end else begin
                ent = exp_q.pop_front();
                chk({tag, ".rd"}, 32'(reg_waddr_o), 32'(ent[36:32]));
                chk({tag, ".data"}, reg_wdata_o, ent[31:0]);
            end
        end
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        step();
        drive(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
        #4;
        chk({tag, ".after_req"}, 32'(dbus_req_o), 32'd0);
        chk({tag, ".after_stall"}, 32'(stall_req_o), 32'd0);
        step();
    endtask

    task automatic misalign_txn(input string tag, input logic [3:0] op, input logic [31:0] addr);
        drive(op, addr, 5'd4, 1'b1, 32'hFFFF_FFFF);
        #4;
        chk({tag, ".pulse"}, 32'(misalign_o), 32'd1);
        chk({tag, ".req"}, 32'(dbus_req_o), 32'd0);
        chk({tag, ".stall"}, 32'(stall_req_o), 32'd0);
        chk({tag, ".we"}, 32'(reg_we_o), 32'd0);
        step();
        drive(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
        #4;
        chk({tag, ".pulse_end"}, 32'(misalign_o), 32'd0);
        chk({tag, ".req_after"}, 32'(dbus_req_o), 32'd0);
        step();
    endtask

    initial begin
        rst           = 1'b1;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'h0;
        drive(4'd0, 32'h1234, 5'd5, 1'b1, 32'h0);
        step();
        step();
        #4;
        chk("rst.we", 32'(reg_we_o), 32'd0);
        chk("rst.waddr", 32'(reg_waddr_o), 32'd0);
        chk("rst.wdata", reg_wdata_o, 32'd0);
        chk("rst.req", 32'(dbus_req_o), 32'd0);
        chk("rst.stall", 32'(stall_req_o), 32'd0);
        step();
        rst = 1'b0;

        // Pass-through of a non-memory op.
        drive(4'd0, 32'h1234, 5'd5, 1'b1, 32'h0);
        #4;
        chk("none.waddr", 32'(reg_waddr_o), 32'd5);
        chk("none.wdata", reg_wdata_o, 32'h1234);
        chk("none.we", 32'(reg_we_o), 32'd1);
        chk("none.stall", 32'(stall_req_o), 32'd0);
        chk("none.req", 32'(dbus_req_o), 32'd0);
        step();

        mem_txn("lb",     4'd1, 32'h103, 5'd3, 32'h0,         32'h80FF_FFFF, 0, 0, 32'h100, 4'b1000, 32'h0,         32'hFFFF_FF80, 2);
        mem_txn("lbu",    4'd4, 32'h103, 5'd3, 32'h0,         32'h80FF_FFFF, 0, 0, 32'h100, 4'b1000, 32'h0,         32'h0000_0080, 2);
        mem_txn("lb1",    4'd1, 32'h101, 5'd11, 32'h0,        32'h0000_7F00, 1, 1, 32'h100, 4'b0010, 32'h0,         32'h0000_007F, 4);
        mem_txn("sh",     4'd7, 32'h202, 5'd9, 32'hAAAA_BEEF, 32'h0,         2, 0, 32'h200, 4'b1100, 32'hBEEF_BEEF, 32'h0,         4);
        mem_txn("lh_wt",  4'd2, 32'h010, 5'd6, 32'h0,         32'h0000_7FFF, 0, 4, 32'h010, 4'b0011, 32'h0,         32'h0000_7FFF, 6);
        mem_txn("lh_neg", 4'd2, 32'h012, 5'd8, 32'h0,         32'h8001_0000, 1, 0, 32'h010, 4'b1100, 32'h0,         32'hFFFF_8001, 3);
        mem_txn("lhu",    4'd5, 32'h012, 5'd8, 32'h0,         32'h8001_0000, 0, 1, 32'h010, 4'b1100, 32'h0,         32'h0000_8001, 3);
        mem_txn("sw",     4'd8, 32'h300, 5'd1, 32'h1234_5678, 32'h0,         1, 0, 32'h300, 4'b1111, 32'h1234_5678, 32'h0,         3);
        mem_txn("sb",     4'd6, 32'h301, 5'd1, 32'h0000_005A, 32'h0,         0, 0, 32'h300, 4'b0010, 32'h5A5A_5A5A, 32'h0,         2);
        mem_txn("lw_x0",  4'd3, 32'h020, 5'd0, 32'h0,         32'hDEAD_BEEF, 0, 2, 32'h020, 4'b1111, 32'h0,         32'hDEAD_BEEF, 4);

        misalign_txn("mis_lw", 4'd3, 32'h106);
        misalign_txn("mis_lh", 4'd2, 32'h011);
        misalign_txn("mis_sw", 4'd8, 32'h302);

        // Reset while a store request is waiting for a grant.
        drive(4'd8, 32'h400, 5'd2, 1'b1, 32'h1111_1111);
        step();
        dbus_gnt_i = 1'b0;
        #4;
        chk("rreq.req_before", 32'(dbus_req_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rreq.req_drop", 32'(dbus_req_o), 32'd0);
        chk("rreq.stall_drop", 32'(stall_req_o), 32'd0);
        step();
        rst = 1'b0;
        drive(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
        #4;
        chk("rreq.idle_req", 32'(dbus_req_o), 32'd0);
        step();

        // Reset while a load waits for rvalid; the late rvalid must be ignored.
        drive(4'd3, 32'h040, 5'd7, 1'b1, 32'h0);
        step();
        dbus_gnt_i = 1'b1;
        #4;
        chk("rwait.req", 32'(dbus_req_o), 32'd1);
        step();
        dbus_gnt_i = 1'b0;
        #4;
        chk("rwait.stall_before", 32'(stall_req_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rwait.stall_drop", 32'(stall_req_o), 32'd0);
        chk("rwait.req_drop", 32'(dbus_req_o), 32'd0);
        step();
        rst = 1'b0;
        drive(4'd0, 32'h0, 5'd0, 1'b0, 32'h0);
        step();
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'hCAFE_F00D;
        #4;
        chk("rwait.late_rv_we", 32'(reg_we_o), 32'd0);
        chk("rwait.late_rv_stall", 32'(stall_req_o), 32'd0);
        step();
        dbus_rvalid_i = 1'b0;
        #4;
        chk("rwait.after_we", 32'(reg_we_o), 32'd0);
        chk("rwait.after_req", 32'(dbus_req_o), 32'd0);
        step();

        chk("sb.leftover", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
